regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard_if.sv | 39 +++
 rtl/regfile_scoreboard.sv | 119 +++++++++++
 tb/tb_regfile_scoreboard.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Register file / scoreboard port bundle.
// master drives addresses, writeback and allocation; slave returns data.
interface regfile_scoreboard_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
);
   localparam int AW = $clog2(NREGS);

   logic [AW-1:0]   rs1_addr;
   logic [AW-1:0]   rs2_addr;
   logic [XLEN-1:0] rd1;
   logic [XLEN-1:0] rd2;
   logic            rs1_busy;
   logic            rs2_busy;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [XLEN-1:0] wr_data;
   logic            alloc_en;
   logic [AW-1:0]   alloc_addr;
   logic            ready;

   modport master (
      output rs1_addr, rs2_addr,
      output wr_en, wr_addr, wr_data,
      output alloc_en, alloc_addr,
      input  rd1, rd2,
      input  rs1_busy, rs2_busy,
      input  ready
   );

   modport slave (
      input  rs1_addr, rs2_addr,
      input  wr_en, wr_addr, wr_data,
      input  alloc_en, alloc_addr,
      output rd1, rd2,
      output rs1_busy, rs2_busy,
      output ready
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with per-register pending scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback to reads.
module regfile_scoreboard #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input logic               clk,
   input logic               rst,
   regfile_scoreboard_if.slave bus
);
   localparam int AW = $clog2(NREGS);
   localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
   localparam logic [AW-1:0] ONE  = AW'(1);

   typedef enum logic {
      CLEAR,
      RUN
   } state_t;

   state_t           state;
   logic             ready_q;
   logic [AW-1:0]    idx;
   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;

   logic            live;
   logic            wr_ok;
   logic            wr_clr;
   logic            al_ok;
   logic            hit1;
   logic            hit2;
   logic [XLEN-1:0] rd1;
   logic [XLEN-1:0] rd2;
   logic            busy1;
   logic            busy2;

   // Everything is held off while in reset or sweeping.
   assign live   = ready_q & ~rst;
   assign wr_ok  = live & bus.wr_en & (bus.wr_addr != '0);
   assign wr_clr = live & bus.wr_en;
   assign al_ok  = live & bus.alloc_en & (bus.alloc_addr != '0);

   // Sweep sequencer: clear x1..x(N-1) once per reset, then run.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         ready_q <= 1'b0;
         idx     <= ONE;
      end else begin
         unique case (state)
            CLEAR: begin
               if (idx == LAST) begin
                  state   <= RUN;
                  ready_q <= 1'b1;
               end else begin
                  idx <= idx + ONE;
               end
            end
            RUN: begin
               ready_q <= 1'b1;
            end
            default: begin
               state   <= CLEAR;
               ready_q <= 1'b0;
               idx     <= ONE;
            end
         endcase
      end
   end

   // Storage: the sweep is its only initialisation; x0 is never written.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CLEAR)
            regs[idx] <= '0;
         else if (wr_ok)
            regs[bus.wr_addr] <= bus.wr_data;
      end
   end

   // Scoreboard: writeback clears, allocation sets; alloc applied last wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
      end else begin
         if (wr_clr)
            busy[bus.wr_addr] <= 1'b0;
         if (al_ok)
            busy[bus.alloc_addr] <= 1'b1;
      end
   end

   // Read ports and pending flags, with optional same-cycle forwarding.
   always_comb begin
      hit1  = 1'b0;
      hit2  = 1'b0;
`ifdef REGFILE_BYPASS_EN
      hit1  = wr_ok & (bus.wr_addr == bus.rs1_addr);
      hit2  = wr_ok & (bus.wr_addr == bus.rs2_addr);
`else
      hit1  = 1'b0;
      hit2  = 1'b0;
`endif
      rd1   = '0;
      rd2   = '0;
      if (live && bus.rs1_addr != '0)
         rd1 = hit1 ? bus.wr_data : regs[bus.rs1_addr];
      if (live && bus.rs2_addr != '0)
         rd2 = hit2 ? bus.wr_data : regs[bus.rs2_addr];
      busy1 = live & busy[bus.rs1_addr] & ~hit1;
      busy2 = live & busy[bus.rs2_addr] & ~hit2;
   end

   assign bus.rd1      = rd1;
   assign bus.rd2      = rd2;
   assign bus.rs1_busy = busy1;
   assign bus.rs2_busy = busy2;
   assign bus.ready    = live;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomised and directed checks of regfile_scoreboard against a
// behavioural model; honours REGFILE_BYPASS_EN when defined.
module tb_regfile_scoreboard;
   localparam int XLEN  = 32;
   localparam int NREGS = 32;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   cnt;

   regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

   regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] m_regs [NREGS];
   bit          m_busy [NREGS];
   bit          m_ready;
   int          m_left;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic bit fwd(input logic [4:0] a);
      bit h;
      h = 1'b0;
`ifdef REGFILE_BYPASS_EN
      h = m_ready && !rst && bus.wr_en && bus.wr_addr != 0
          && bus.wr_addr == a;
`endif
      return h;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (!(m_ready && !rst) || a == 0) return 32'h0;
      if (fwd(a)) return bus.wr_data;
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      return m_ready && !rst && m_busy[a] && !fwd(a);
   endfunction

   task automatic check_model();
      chk("ready", 32'(bus.ready), 32'(m_ready && !rst));
      chk("rd1", bus.rd1, exp_rd(bus.rs1_addr));
      chk("rd2", bus.rd2, exp_rd(bus.rs2_addr));
      chk("rs1_busy", 32'(bus.rs1_busy), 32'(exp_busy(bus.rs1_addr)));
      chk("rs2_busy", 32'(bus.rs2_busy), 32'(exp_busy(bus.rs2_addr)));
   endtask

   task automatic edge_step();
      @(posedge clk);
      if (rst) begin
         m_ready = 1'b0;
         m_left  = NREGS - 1;
         for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = 32'h0;
            m_busy[i] = 1'b0;
         end
      end else if (!m_ready) begin
         m_left--;
         if (m_left == 0) m_ready = 1'b1;
      end else begin
         if (bus.wr_en && bus.wr_addr != 0)
            m_regs[bus.wr_addr] = bus.wr_data;
         if (bus.wr_en) m_busy[bus.wr_addr] = 1'b0;
         if (bus.alloc_en && bus.alloc_addr != 0)
            m_busy[bus.alloc_addr] = 1'b1;
      end
      #1;
   endtask

   task automatic step();
      #2;
      check_model();
      edge_step();
   endtask

   task automatic idle();
      bus.wr_en    = 1'b0;
      bus.alloc_en = 1'b0;
   endtask

   task automatic wait_ready(input string tag, input bit poke);
      cnt = 0;
      #2;
      while (!bus.ready && cnt < 40) begin
         check_model();
         edge_step();
         cnt++;
         if (poke) begin
            bus.wr_en   = (cnt < 20);
            bus.wr_addr = 5'd5;
            bus.wr_data = 32'hAAAA_5555;
         end
         #2;
      end
      chk(tag, cnt, 31);
      check_model();
      edge_step();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      m_ready = 1'b0;
      m_left  = NREGS - 1;
      for (int i = 0; i < NREGS; i++) begin
         m_regs[i] = 32'h0;
         m_busy[i] = 1'b0;
      end
      bus.rs1_addr   = 5'd0;
      bus.rs2_addr   = 5'd0;
      bus.wr_en      = 1'b0;
      bus.wr_addr    = 5'd0;
      bus.wr_data    = 32'h0;
      bus.alloc_en   = 1'b0;
      bus.alloc_addr = 5'd0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      step();
      rst = 1'b0;
      bus.rs1_addr = 5'd1;
      bus.rs2_addr = 5'd31;
      wait_ready("sweep_len", 1'b0);

      bus.wr_en   = 1'b1;
      bus.wr_addr = 5'd5;
      bus.wr_data = 32'h0000_0005;
      step();
      idle();
      bus.rs1_addr = 5'd5;
      #2;
      chk("x5_read", bus.rd1, 32'h5);
      step();
      bus.wr_en   = 1'b1;
      bus.wr_addr = 5'd0;
      bus.wr_data = 32'hFFFF_FFFF;
      step();
      idle();
      bus.rs1_addr = 5'd0;
      bus.rs2_addr = 5'd0;
      #2;
      chk("x0_read", bus.rd1, 32'h0);
      step();

      bus.wr_en   = 1'b1;
      bus.wr_addr = 5'd7;
      bus.wr_data = 32'h1234_5678;
      step();
      bus.alloc_en   = 1'b1;
      bus.alloc_addr = 5'd7;
      bus.wr_en      = 1'b0;
      step();
      bus.alloc_en = 1'b0;
      bus.wr_en    = 1'b1;
      bus.wr_data  = 32'hDEAD_BEEF;
      bus.rs2_addr = 5'd7;
      #2;
`ifdef REGFILE_BYPASS_EN
      chk("fwd_rd2", bus.rd2, 32'hDEAD_BEEF);
      chk("fwd_busy", 32'(bus.rs2_busy), 32'h0);
`else
      chk("old_rd2", bus.rd2, 32'h1234_5678);
      chk("old_busy", 32'(bus.rs2_busy), 32'h1);
`endif
      step();
      idle();
      #2;
      chk("new_rd2", bus.rd2, 32'hDEAD_BEEF);
      step();

      bus.alloc_en   = 1'b1;
      bus.alloc_addr = 5'd3;
      step();
      idle();
      bus.rs1_addr = 5'd3;
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("x3_pending", 32'(bus.rs1_busy), 32'h1);
         check_model();
         edge_step();
      end
      bus.wr_en   = 1'b1;
      bus.wr_addr = 5'd3;
      bus.wr_data = 32'h11;
      step();
      idle();
      #2;
      chk("x3_done_busy", 32'(bus.rs1_busy), 32'h0);
      chk("x3_done_rd", bus.rd1, 32'h11);
      step();

      bus.alloc_en   = 1'b1;
      bus.alloc_addr = 5'd9;
      bus.wr_en      = 1'b1;
      bus.wr_addr    = 5'd9;
      bus.wr_data    = 32'h22;
      step();
      idle();
      bus.rs1_addr = 5'd9;
      #2;
      chk("x9_busy", 32'(bus.rs1_busy), 32'h1);
      chk("x9_rd", bus.rd1, 32'h22);
      step();

      for (int i = 0; i < 400; i++) begin
         rst            = ($urandom_range(0, 99) == 0);
         bus.rs1_addr   = 5'($urandom_range(0, 31));
         bus.rs2_addr   = 5'($urandom_range(0, 31));
         bus.wr_en      = 1'($urandom_range(0, 1));
         bus.wr_addr    = 5'($urandom_range(0, 31));
         bus.wr_data    = $urandom;
         bus.alloc_en   = 1'($urandom_range(0, 1));
         bus.alloc_addr = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) bus.rs1_addr = bus.wr_addr;
         if ($urandom_range(0, 3) == 0) bus.rs2_addr = bus.alloc_addr;
         step();
      end
      idle();

      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (9) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.rs1_addr = 5'd5;
      bus.rs2_addr = 5'd10;
      bus.wr_en    = 1'b1;
      bus.wr_addr  = 5'd5;
      bus.wr_data  = 32'hAAAA_5555;
      wait_ready("restart_len", 1'b1);
      idle();
      #2;
      chk("x5_cleared", bus.rd1, 32'h0);
      chk("x10_cleared", bus.rd2, 32'h0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: sim time exceeded");
      $fatal(1, "timeout");
   end
endmodule
